// File: rtl/axis_sum_accum_pkg.sv
// axis_sum_accum_pkg
//   Shared definitions for the AXI-Stream sum accumulator:
//   - state_t   : accumulator FSM states (S_ACC collecting, S_OUT result held)
//   - calc_rw() : result width helper, RW = 8*bytes + guard bits
package axis_sum_accum_pkg;

  typedef enum logic {
    S_ACC = 1'b0,
    S_OUT = 1'b1
  } state_t;

  function automatic int unsigned calc_rw(input int unsigned wdata_byte,
                                          input int unsigned guard_bits);
    return 8 * wdata_byte + guard_bits;
  endfunction

endpackage

// File: rtl/axis_sum_accum.sv
// axis_sum_accum
//   Sums PAR_ACC_LEN consecutive beats of an unsigned AXI-Stream and emits
//   one widened result per frame. Full throughput: the result handshake and
//   the first beat of the next frame may complete in the same cycle.
//
// Parameters
//   PAR_WDATA_BYTE : input width in bytes (1..2), W = 8*PAR_WDATA_BYTE
//   PAR_ACC_LEN    : beats per result (2..256)
//   PAR_GUARD_BITS : extra result bits (1..8), RW = W + PAR_GUARD_BITS
//
// Ports
//   aclk, areset      : clock (rising edge), asynchronous active-high reset
//   s_axis_tdata/tvalid/tready : input stream (W bits)
//   m_axis_tdata/tvalid/tready : result stream (RW bits)
//
// Configuration
//   AXIS_SUM_ACCUM_SAT_EN : when defined, the accumulator clamps to all-ones
//                           on overflow; otherwise it wraps modulo 2^RW.
module axis_sum_accum
  import axis_sum_accum_pkg::*;
#(
  parameter int unsigned PAR_WDATA_BYTE = 2,
  parameter int unsigned PAR_ACC_LEN    = 4,
  parameter int unsigned PAR_GUARD_BITS = 4
) (
  input  logic                                              aclk,
  input  logic                                              areset,
  input  logic [8*PAR_WDATA_BYTE-1:0]                       s_axis_tdata,
  input  logic                                              s_axis_tvalid,
  output logic                                              s_axis_tready,
  output logic [calc_rw(PAR_WDATA_BYTE, PAR_GUARD_BITS)-1:0] m_axis_tdata,
  output logic                                              m_axis_tvalid,
  input  logic                                              m_axis_tready
);

  localparam int unsigned W  = 8 * PAR_WDATA_BYTE;
  localparam int unsigned RW = calc_rw(PAR_WDATA_BYTE, PAR_GUARD_BITS);
  localparam int unsigned CW = $clog2(PAR_ACC_LEN);
  localparam logic [CW-1:0] LAST_BEAT = CW'(PAR_ACC_LEN - 1);

  state_t          state_q,  state_d;
  logic [RW-1:0]   acc_q,    acc_d;
  logic [CW-1:0]   cnt_q,    cnt_d;
  logic [RW-1:0]   out_q,    out_d;
  logic            mvalid_q, mvalid_d;

  logic [RW-1:0]   beat_ext;
  logic [RW-1:0]   sum;
  logic            accept;

  assign beat_ext = {{PAR_GUARD_BITS{1'b0}}, s_axis_tdata};

`ifdef AXIS_SUM_ACCUM_SAT_EN
  logic [RW:0] sum_ext;
  assign sum_ext = {1'b0, acc_q} + {1'b0, beat_ext};
  // Once clamped the accumulator is all-ones, so any further non-zero beat
  // overflows again and the clamp holds until the frame ends.
  assign sum     = sum_ext[RW] ? '1 : sum_ext[RW-1:0];
`else
  assign sum     = acc_q + beat_ext;
`endif

  // In S_OUT the input is only opened when the result is being taken, so a
  // beat accepted there always lands in an empty next frame.
  assign s_axis_tready = (state_q == S_ACC) || m_axis_tready;
  assign accept        = s_axis_tvalid && s_axis_tready;

  always_comb begin
    state_d  = state_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    out_d    = out_q;
    case (state_q)
      S_ACC: begin
        if (accept) begin
          if (cnt_q == LAST_BEAT) begin
            out_d   = sum;
            acc_d   = '0;
            cnt_d   = '0;
            state_d = S_OUT;
          end else begin
            acc_d = sum;
            cnt_d = cnt_q + CW'(1);
          end
        end
      end
      S_OUT: begin
        if (m_axis_tready) begin
          state_d = S_ACC;
          // Accumulator is zero here, so sum equals the beat itself; with
          // PAR_ACC_LEN >= 2 this beat can never close a frame.
          if (accept) begin
            acc_d = sum;
            cnt_d = CW'(1);
          end
        end
      end
      default: state_d = S_ACC;
    endcase
    mvalid_d = (state_d == S_OUT);
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      state_q  <= S_ACC;
      acc_q    <= '0;
      cnt_q    <= '0;
      out_q    <= '0;
      mvalid_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      out_q    <= out_d;
      mvalid_q <= mvalid_d;
    end
  end

  assign m_axis_tdata  = out_q;
  assign m_axis_tvalid = mvalid_q;

endmodule

// File: tb/tb_axis_sum_accum.sv
// Directed testbench for axis_sum_accum: LEN=4 instance for framing,
// backpressure, throughput, reset and gap cases; LEN=17 instance for
// overflow behaviour (wrap by default, clamp with AXIS_SUM_ACCUM_SAT_EN).
module tb_axis_sum_accum;

  logic        aclk = 1'b0;
  logic        areset;

  logic [15:0] s_tdata;
  logic        s_tvalid;
  logic        s_tready;
  logic [19:0] m_tdata;
  logic        m_tvalid;
  logic        m_tready;

  logic [15:0] s17_tdata;
  logic        s17_tvalid;
  logic        s17_tready;
  logic [19:0] m17_tdata;
  logic        m17_tvalid;
  logic        m17_tready;

  int unsigned errors = 0;
  int unsigned checks = 0;

  always #5 aclk = ~aclk;

  axis_sum_accum #(
    .PAR_WDATA_BYTE(2),
    .PAR_ACC_LEN   (4),
    .PAR_GUARD_BITS(4)
  ) dut (
    .aclk         (aclk),
    .areset       (areset),
    .s_axis_tdata (s_tdata),
    .s_axis_tvalid(s_tvalid),
    .s_axis_tready(s_tready),
    .m_axis_tdata (m_tdata),
    .m_axis_tvalid(m_tvalid),
    .m_axis_tready(m_tready)
  );

  axis_sum_accum #(
    .PAR_WDATA_BYTE(2),
    .PAR_ACC_LEN   (17),
    .PAR_GUARD_BITS(4)
  ) dut17 (
    .aclk         (aclk),
    .areset       (areset),
    .s_axis_tdata (s17_tdata),
    .s_axis_tvalid(s17_tvalid),
    .s_axis_tready(s17_tready),
    .m_axis_tdata (m17_tdata),
    .m_axis_tvalid(m17_tvalid),
    .m_axis_tready(m17_tready)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Present one beat for one clock; returns at the following negedge.
  task automatic send(input logic [15:0] d);
    s_tdata  = d;
    s_tvalid = 1'b1;
    @(negedge aclk);
    s_tvalid = 1'b0;
    s_tdata  = '0;
  endtask

  task automatic idle(input int unsigned n);
    for (int unsigned i = 0; i < n; i++) @(negedge aclk);
  endtask

  logic [19:0] exp17;

  initial begin
    areset     = 1'b1;
    s_tdata    = '0;
    s_tvalid   = 1'b0;
    m_tready   = 1'b1;
    s17_tdata  = '0;
    s17_tvalid = 1'b0;
    m17_tready = 1'b1;
    idle(2);

    // Reset state
    chk("rst_m_tvalid", 32'(m_tvalid), 32'd0);
    chk("rst_m_tdata",  32'(m_tdata),  32'd0);
    chk("rst_s_tready", 32'(s_tready), 32'd1);
    areset = 1'b0;
    idle(1);
    chk("rel_s_tready", 32'(s_tready), 32'd1);

    // Basic frame 1+2+3+4
    send(16'd1); send(16'd2); send(16'd3);
    chk("basic_no_early_valid", 32'(m_tvalid), 32'd0);
    send(16'd4);
    chk("basic_valid", 32'(m_tvalid), 32'd1);
    chk("basic_data",  32'(m_tdata),  32'd10);
    idle(1);
    chk("basic_one_valid_cycle", 32'(m_tvalid), 32'd0);

    // Backpressure: result held 5 cycles with s_tready low
    m_tready = 1'b0;
    send(16'd1); send(16'd2); send(16'd3); send(16'd4);
    for (int unsigned i = 0; i < 5; i++) begin
      chk("bp_valid_held",  32'(m_tvalid), 32'd1);
      chk("bp_data_held",   32'(m_tdata),  32'd10);
      chk("bp_s_tready_lo", 32'(s_tready), 32'd0);
      if (i < 4) idle(1);
    end
    m_tready = 1'b1;
    #1;
    chk("bp_s_tready_follow", 32'(s_tready), 32'd1);
    idle(1);
    chk("bp_released", 32'(m_tvalid), 32'd0);
    chk("bp_back_to_acc", 32'(s_tready), 32'd1);

    // Continuous stream, 8 beats of 1: results 4 and 4, no bubble
    for (int unsigned i = 0; i < 8; i++) begin
      s_tdata  = 16'd1;
      s_tvalid = 1'b1;
      #1;
      chk("stream_s_tready", 32'(s_tready), 32'd1);
      @(negedge aclk);
      chk("stream_m_tvalid", 32'(m_tvalid), (i == 3 || i == 7) ? 32'd1 : 32'd0);
      if (i == 3 || i == 7) chk("stream_m_tdata", 32'(m_tdata), 32'd4);
    end
    s_tvalid = 1'b0;
    s_tdata  = '0;
    idle(1);
    chk("stream_done", 32'(m_tvalid), 32'd0);

    // Reset mid-frame discards the partial sum
    send(16'd5); send(16'd6);
    areset = 1'b1;
    idle(1);
    chk("midrst_m_tvalid", 32'(m_tvalid), 32'd0);
    areset = 1'b0;
    send(16'd1); send(16'd1); send(16'd1);
    chk("midrst_no_early", 32'(m_tvalid), 32'd0);
    send(16'd1);
    chk("midrst_valid", 32'(m_tvalid), 32'd1);
    chk("midrst_data",  32'(m_tdata),  32'd4);
    idle(1);
    chk("midrst_single", 32'(m_tvalid), 32'd0);

    // Pending result dropped by reset
    m_tready = 1'b0;
    send(16'd2); send(16'd2); send(16'd2); send(16'd2);
    chk("drop_pending", 32'(m_tvalid), 32'd1);
    areset = 1'b1;
    #1;
    chk("drop_valid_cleared", 32'(m_tvalid), 32'd0);
    chk("drop_data_cleared",  32'(m_tdata),  32'd0);
    idle(1);
    areset   = 1'b0;
    m_tready = 1'b1;
    idle(1);

    // tvalid gaps: 7,8,9,10 -> 34
    send(16'd7);  idle(2);
    send(16'd8);  idle(1);
    send(16'd9);
    for (int unsigned i = 0; i < 3; i++) begin
      chk("gap_no_valid", 32'(m_tvalid), 32'd0);
      idle(1);
    end
    send(16'd10);
    chk("gap_valid", 32'(m_tvalid), 32'd1);
    chk("gap_data",  32'(m_tdata),  32'd34);
    idle(1);
    chk("gap_single", 32'(m_tvalid), 32'd0);

    // LEN=17 overflow: 17*0xFFFF = 0x10FFEF
`ifdef AXIS_SUM_ACCUM_SAT_EN
    exp17 = 20'hFFFFF;
`else
    exp17 = 20'h0FFEF;
`endif
    for (int unsigned i = 0; i < 17; i++) begin
      s17_tdata  = 16'hFFFF;
      s17_tvalid = 1'b1;
      @(negedge aclk);
      if (i == 15) chk("len17_no_early", 32'(m17_tvalid), 32'd0);
    end
    s17_tvalid = 1'b0;
    s17_tdata  = '0;
    chk("len17_valid", 32'(m17_tvalid), 32'd1);
    chk("len17_data",  32'(m17_tdata),  32'(exp17));
    idle(1);
    chk("len17_single", 32'(m17_tvalid), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
